afifo_read_checker: RTL and testbench
=====================================

# afifo_read_checker

Read-side consumer for the async-FIFO bring-up design. It drains a first-word-fall-through async FIFO on its own clock and checks that the 12-bit words arrive as a contiguous +1 sequence that wraps modulo 4096. It counts good words and latches the first mismatch. Its state is shown on the board LEDs and exported for the bench. It sits directly downstream of the FIFO that the 12-bit incrementing producer fills.

## Interface
- `STARTUP_DELAY`, default 2^24: clk cycles to wait after reset before the first read. The simulation build overrides this to 8.
- `READ_DIV`, default 4: a read is allowed once every `READ_DIV` cycles, so the FIFO fills and the full path is exercised. The minimum is 1, which allows a read every cycle.
- `clk` input, 1 bit: read-domain clock.
- `rst_` input, 1 bit: asynchronous, active-low reset. Release is synchronous to `clk` upstream.
- `rok` input, 1 bit: FIFO not empty. `rd` holds the head word while this is high.
- `rd` input, 12 bits: FIFO head data.
- `r` output, 1 bit: pop strobe. The FIFO pops on any rising edge where `r & rok`.
- `count` output, 16 bits: number of words checked good, wrapping.
- `err` output, 1 bit: sticky mismatch flag.
- `err_exp` output, 12 bits: expected value at the first mismatch.
- `err_got` output, 12 bits: received value at the first mismatch.
- `led` output, 4 bits: board status.

## Operation
- States are DELAY, FIRST, CHECK and HALT. Reset state is DELAY.
- Reset values:
  - `r`=0, `count`=0, `err`=0, `err_exp`=0, `err_got`=0, `led`=0.
  - Internal `expected`=0, delay counter 0, divider counter 0.
- DELAY:
  - Increment the delay counter each cycle.
  - On the cycle the counter equals `STARTUP_DELAY-1`, go to FIRST.
  - Nothing is popped in this state.
- Divider tick `tick`:
  - The divider counter runs from 0 to `READ_DIV-1` and wraps, only in FIRST and CHECK.
  - `tick` = (counter == 0).
- `r` = (state ∈ {FIRST, CHECK}) & `tick` & `rok`. It is combinational from registered state and `rok`. No read is issued when the FIFO is empty.
- FIRST:
  - On a pop, set `expected` ← `rd`+1 (12-bit wrap) and go to CHECK.
  - The first word is accepted unconditionally, since the producer's start value is not fixed.
  - `count` is not incremented.
- CHECK, on a pop:
  - If `rd == expected`: `expected` ← `rd`+1 mod 4096, and `count` ← `count`+1 mod 65536.
  - Otherwise: `err` ← 1, `err_exp` ← `expected`, `err_got` ← `rd`, go to HALT. `count` is unchanged.
- HALT:
  - `r` is held at 0 and all outputs are frozen.
  - Only reset exits this state.
- `led`, registered:
  - DELAY = 0000, FIRST = 0001.
  - CHECK = {0, 1, `count[15]`, `count[14]`}, which gives a heartbeat.
  - HALT = 1111.

## Timing
- Pop-to-check latency is 0. `rd` is compared on the same edge that pops it. `count`, `err` and `err_*` update on that edge and are visible the next cycle.
- The maximum read rate is one word per `READ_DIV` cycles. With `READ_DIV`=1, back-to-back pops on consecutive cycles must each be checked.
- If `rok` is low on a tick, that tick is lost. The next read opportunity is the next tick.
- Wrap: `expected` 0xFFF → 0x000 is legal. `rd`=0x000 after 0xFFF is good.
- A mismatch on the same cycle as a `count` rollover leaves `count` unchanged.
- Asserting `rst_` in any state:
  - Immediately (asynchronously) forces DELAY, `r`=0 and all outputs to their reset values.
  - A pop in flight on that edge is discarded.

## Test plan
- Reset, `STARTUP_DELAY`=8, `rok`=1, `rd` stepping 0x005, 0x006, … on each pop.
  - Required: `r` stays 0 for 8 cycles.
  - Required: the first pop is 0x005 and is not counted.
  - Required: after 10 further pops, `count`=10, `err`=0.
- `READ_DIV`=4 with `rok` held 1.
  - Required: `r` pulses exactly every 4th cycle, one cycle wide.
  - Required: `rok` dropped low for 6 cycles gives no `r` during that window.
- Sequence 0xFFE, 0xFFF, 0x000, 0x001.
  - Required: `count`=3, `err`=0.
- Sequence 0x010, 0x011, 0x013.
  - Required: `err`=1, `err_exp`=0x012, `err_got`=0x013.
  - Required: `count`=1, `led`=1111, and `r` stays 0 thereafter even with `rok`=1.
- `READ_DIV`=1, 70000 contiguous words.
  - Required: `count` wraps to 70000−1−65536 = 4463, and `led[1:0]` toggles.
- Assert `rst_`=0 mid-CHECK, in the same cycle `r`=1.
  - Required: `r`, `count` and `err` go to 0 without waiting for a clock edge.
  - Required: after release, DELAY is re-entered and the checker restarts at FIRST.

Source files
------------

// File: rtl/afifo_read_checker_if.sv
// Read-side handshake between a first-word-fall-through async FIFO and its consumer.
// master = consumer (issues pops), slave = FIFO (presents head word and not-empty).
interface afifo_read_checker_if;
    localparam int unsigned DW = 12;

    logic          rok;
    logic [DW-1:0] rd;
    logic          r;

    modport master (input rok, input rd, output r);
    modport slave  (output rok, output rd, input r);
endinterface

// File: rtl/afifo_read_checker.sv
// Drains an FWFT async FIFO at a throttled rate and checks the words form a
// contiguous +1 sequence modulo 4096; counts good words and latches the first mismatch.
module afifo_read_checker #(
    parameter int unsigned STARTUP_DELAY = 16777216,
    parameter int unsigned READ_DIV      = 4
) (
    input  logic                        clk,
    input  logic                        rst_,
    afifo_read_checker_if.master        fifo,
    output logic [15:0]                 count,
    output logic                        err,
    output logic [11:0]                 err_exp,
    output logic [11:0]                 err_got,
    output logic [3:0]                  led
);
    localparam int unsigned DW    = 12;
    localparam int unsigned CW    = 16;
    localparam int unsigned DLY_W = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
    localparam int unsigned DIV_W = (READ_DIV > 1) ? $clog2(READ_DIV) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STARTUP_DELAY - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(READ_DIV - 1);

    typedef enum logic [1:0] {
        S_DELAY = 2'd0,
        S_FIRST = 2'd1,
        S_CHECK = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t           state;
    logic [DLY_W-1:0] dly_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [DW-1:0]    expected;

    logic             active;
    logic             tick;
    logic             pop;
    logic [DW-1:0]    rd_inc;
    logic [CW-1:0]    count_inc;

    // Pop strobe is combinational so the head word is checked on the edge that pops it.
    assign active    = (state == S_FIRST) || (state == S_CHECK);
    assign tick      = (div_cnt == '0);
    assign pop       = active && tick && fifo.rok;
    assign fifo.r    = pop;
    assign rd_inc    = fifo.rd + DW'(1);
    assign count_inc = count + CW'(1);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= S_DELAY;
            dly_cnt  <= '0;
            div_cnt  <= '0;
            expected <= '0;
            count    <= '0;
            err      <= 1'b0;
            err_exp  <= '0;
            err_got  <= '0;
            led      <= 4'b0000;
        end else begin
            // Divider only runs while reading; it freezes in HALT.
            if (active) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            end
            case (state)
                S_DELAY: begin
                    dly_cnt <= dly_cnt + DLY_W'(1);
                    if (dly_cnt == DLY_LAST) begin
                        state <= S_FIRST;
                        led   <= 4'b0001;
                    end
                end
                S_FIRST: begin
                    // Producer start value is arbitrary, so the first word seeds the sequence.
                    if (pop) begin
                        expected <= rd_inc;
                        state    <= S_CHECK;
                        led      <= {2'b01, count[15:14]};
                    end
                end
                S_CHECK: begin
                    if (pop) begin
                        if (fifo.rd == expected) begin
                            expected <= rd_inc;
                            count    <= count_inc;
                            led      <= {2'b01, count_inc[15:14]};
                        end else begin
                            err     <= 1'b1;
                            err_exp <= expected;
                            err_got <= fifo.rd;
                            state   <= S_HALT;
                            led     <= 4'b1111;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_DELAY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_afifo_read_checker.sv
// Directed bench for afifo_read_checker: one throttled instance (READ_DIV=4) for the
// functional steps and one full-rate instance (READ_DIV=1) for the 70000-word wrap run.
module tb_afifo_read_checker;
    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [15:0] count_a, count_b;
    logic        err_a, err_b;
    logic [11:0] err_exp_a, err_got_a, err_exp_b, err_got_b;
    logic [3:0]  led_a, led_b;

    afifo_read_checker_if ifa ();
    afifo_read_checker_if ifb ();

    afifo_read_checker #(.STARTUP_DELAY(8), .READ_DIV(4)) u_a (
        .clk(clk), .rst_(rst_a), .fifo(ifa),
        .count(count_a), .err(err_a), .err_exp(err_exp_a), .err_got(err_got_a), .led(led_a)
    );

    afifo_read_checker #(.STARTUP_DELAY(8), .READ_DIV(1)) u_b (
        .clk(clk), .rst_(rst_b), .fifo(ifb),
        .count(count_b), .err(err_b), .err_exp(err_exp_b), .err_got(err_got_b), .led(led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          passed;
    int          failed;
    logic [11:0] q_a[$];
    logic        rok_en_a;
    logic        pend_a, pend_b;
    logic        s_r_a;
    logic [11:0] popped_a;
    logic [11:0] rd_b_val;
    int          pops_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        ifa.rok = rok_en_a && (q_a.size() != 0);
        ifa.rd  = (q_a.size() != 0) ? q_a[0] : 12'h000;
        ifb.rok = 1'b1;
        ifb.rd  = rd_b_val;
    endtask

    // One clock: sample the pop strobes for the coming edge, apply the pops after it,
    // then return at the falling edge with the registered outputs settled.
    task automatic cyc();
        #1;
        s_r_a  = ifa.r;
        pend_a = ifa.r && ifa.rok;
        pend_b = ifb.r && ifb.rok;
        @(posedge clk);
        #1;
        if (pend_a) popped_a = q_a.pop_front();
        if (pend_b) begin
            rd_b_val = rd_b_val + 12'd1;
            pops_b++;
        end
        drive();
        @(negedge clk);
    endtask

    task automatic restart_a(input logic [11:0] first, input int n);
        rst_a = 1'b0;
        q_a.delete();
        for (int k = 0; k < n; k++) q_a.push_back(12'(first + 12'(k)));
        rok_en_a = 1'b1;
        drive();
        cyc();
        rst_a = 1'b1;
    endtask

    initial begin
        int  rcnt;
        int  bad;
        int  changes;
        logic [1:0] prev;
        logic started;
        logic hit;

        total = 0; passed = 0; failed = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        rok_en_a = 1'b1; pend_a = 1'b0; pend_b = 1'b0; s_r_a = 1'b0;
        popped_a = 12'h000; rd_b_val = 12'h7F0; pops_b = 0;
        for (int k = 0; k < 17; k++) q_a.push_back(12'(12'h005 + 12'(k)));
        drive();
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Reset values
        check("reset_r",       32'(ifa.r),     32'd0);
        check("reset_count",   32'(count_a),   32'd0);
        check("reset_err",     32'(err_a),     32'd0);
        check("reset_err_exp", 32'(err_exp_a), 32'd0);
        check("reset_err_got", 32'(err_got_a), 32'd0);
        check("reset_led",     32'(led_a),     32'd0);

        // Startup delay, then first word accepted but not counted
        cyc();
        rst_a = 1'b1;
        rcnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (s_r_a) rcnt++;
        end
        check("delay_no_read", 32'(rcnt), 32'd0);
        cyc();
        check("first_read", 32'(s_r_a), 32'd1);
        check("first_word", 32'(popped_a), 32'h005);
        check("first_not_counted", 32'(count_a), 32'd0);
        check("led_check_state", 32'(led_a), 32'b0100);

        // Throttled reads: one-cycle pulse every 4th cycle
        bad = 0; rcnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (s_r_a) rcnt++;
            if (s_r_a != ((i % 4) == 3)) bad++;
        end
        check("div4_pattern_bad", 32'(bad), 32'd0);
        check("count_after_10", 32'(count_a), 32'd10);
        check("err_after_10", 32'(err_a), 32'd0);

        // Empty FIFO on a tick loses that tick
        rok_en_a = 1'b0;
        drive();
        rcnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (s_r_a) rcnt++;
        end
        check("rok_low_no_read", 32'(rcnt), 32'd0);
        rok_en_a = 1'b1;
        drive();
        cyc();
        check("no_read_off_tick", 32'(s_r_a), 32'd0);
        cyc();
        check("read_next_tick", 32'(s_r_a), 32'd1);
        check("resume_word", 32'(popped_a), 32'h010);
        check("resume_count", 32'(count_a), 32'd11);

        // 12-bit wrap is a legal step
        restart_a(12'hFFE, 4);
        for (int i = 0; i < 24; i++) cyc();
        check("wrap_count", 32'(count_a), 32'd3);
        check("wrap_err", 32'(err_a), 32'd0);
        check("wrap_led", 32'(led_a), 32'b0100);

        // Mismatch latches and halts
        restart_a(12'h010, 2);
        q_a.push_back(12'h013);
        q_a.push_back(12'h014);
        drive();
        for (int i = 0; i < 20; i++) cyc();
        check("mis_err", 32'(err_a), 32'd1);
        check("mis_err_exp", 32'(err_exp_a), 32'h012);
        check("mis_err_got", 32'(err_got_a), 32'h013);
        check("mis_count", 32'(count_a), 32'd1);
        check("mis_led", 32'(led_a), 32'b1111);
        rcnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (s_r_a) rcnt++;
        end
        check("halt_no_read", 32'(rcnt), 32'd0);
        check("halt_fifo_left", 32'(q_a.size()), 32'd1);

        // Asynchronous reset while a pop is pending mid-CHECK
        restart_a(12'h100, 16);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cyc();
            if (ifa.r && (count_a >= 16'd2)) hit = 1'b1;
        end
        check("async_setup_found", 32'(hit), 32'd1);
        rst_a = 1'b0;
        #1;
        check("async_r", 32'(ifa.r), 32'd0);
        check("async_count", 32'(count_a), 32'd0);
        check("async_err", 32'(err_a), 32'd0);
        check("async_led", 32'(led_a), 32'd0);
        cyc();
        check("inflight_discarded", 32'(q_a[0]), 32'h103);
        rst_a = 1'b1;
        rcnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (s_r_a) rcnt++;
        end
        check("redelay_no_read", 32'(rcnt), 32'd0);
        cyc();
        check("restart_read", 32'(s_r_a), 32'd1);
        check("restart_word", 32'(popped_a), 32'h103);
        check("restart_count", 32'(count_a), 32'd0);

        // Full-rate run of 70000 contiguous words on the READ_DIV=1 instance
        rst_b = 1'b1;
        changes = 0; started = 1'b0; prev = 2'b00;
        for (int i = 0; i < 70100 && pops_b < 70000; i++) begin
            cyc();
            if (pops_b >= 1) begin
                if (started && (led_b[1:0] != prev)) changes++;
                prev = led_b[1:0];
                started = 1'b1;
            end
        end
        check("b_pops", 32'(pops_b), 32'd70000);
        check("b_count_wrap", 32'(count_b), 32'd4463);
        check("b_err", 32'(err_b), 32'd0);
        check("b_led_changes", 32'(changes), 32'd4);
        check("b_led_final", 32'(led_b), 32'b0100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
